// File: rtl/adder_share_pkg.sv
// Shared types and helpers for the shared-adder controller.
package adder_share_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESP    = 2'd2
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr, wrapping at NREQ.
module rr_arbiter
    import adder_share_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ <= 2) ? 1 : clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic found;
    int   idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (en && !found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/addern.sv
// N-bit ripple adder with carry-out and two's-complement overflow.
module addern #(
    parameter int n = 16
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         carryin,
    output logic [n-1:0] S,
    output logic         carryout,
    output logic         overflow
);

    logic [n:0] full;

    always_comb begin
        full     = {1'b0, a} + {1'b0, b} + {{n{1'b0}}, carryin};
        S        = full[n-1:0];
        carryout = full[n];
        overflow = (a[n-1] == b[n-1]) && (full[n-1] != a[n-1]);
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Time-shares one addern between NREQ valid/ready requesters with a
// registered response port and a sticky signed-overflow flag.
//
//   state   | meaning
//   IDLE    | arbitrate; latch operands and requester id on handshake
//   COMPUTE | registered operands drive the adder; capture result
//   RESP    | hold result until consumer accepts, then advance rr pointer
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int N    = 16,
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N:0]        rsp_sum,
    output logic              rsp_overflow,
    output logic              ovf_sticky,
    input  logic              ovf_clr,
    output logic              busy
);

    state_e          state_q, state_d;
    logic            run_q;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N:0]      sum_q, sum_d;
    logic            ovf_q, ovf_d;
    logic            vld_q, vld_d;
    logic            stk_q, stk_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic [N-1:0]    a_sel, b_sel;
    logic [N-1:0]    add_s;
    logic            add_co, add_ovf;

    // run_q keeps req_ready low while reset is asserted, even though state reads IDLE.
    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (run_q && (state_q == IDLE)),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    addern #(.n(N)) u_add (
        .a        (a_q),
        .b        (b_q),
        .carryin  (1'b0),
        .S        (add_s),
        .carryout (add_co),
        .overflow (add_ovf)
    );

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                a_sel = req_a[i*N +: N];
                b_sel = req_b[i*N +: N];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        vld_d   = vld_q;
        stk_d   = stk_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    a_d     = a_sel;
                    b_d     = b_sel;
                    id_d    = gnt_idx;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                sum_d   = {add_co, add_s};
                ovf_d   = add_ovf;
                vld_d   = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    vld_d   = 1'b0;
                    ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Set takes priority over a coincident clear.
        if (ovf_clr) stk_d = 1'b0;
        if (state_q == COMPUTE && add_ovf) stk_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
            stk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
            stk_q   <= stk_d;
        end
    end

    assign req_ready    = gnt;
    assign rsp_valid    = vld_q;
    assign rsp_id       = id_q;
    assign rsp_sum      = sum_q;
    assign rsp_overflow = ovf_q;
    assign ovf_sticky   = stk_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl (N=16, NREQ=2) with hand-computed expectations.
module tb_adder_share_ctrl;

    localparam int N    = 16;
    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N:0]        rsp_sum;
    logic              rsp_overflow;
    logic              ovf_sticky;
    logic              ovf_clr;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    adder_share_ctrl #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_sum      (rsp_sum),
        .rsp_overflow (rsp_overflow),
        .ovf_sticky   (ovf_sticky),
        .ovf_clr      (ovf_clr),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    task automatic chk_rsp(input string tag, input logic [IDW-1:0] id,
                           input logic [N:0] sum, input logic ovf);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'h1);
        chk({tag, "_id"}, 32'(rsp_id), 32'(id));
        chk({tag, "_sum"}, 32'(rsp_sum), 32'(sum));
        chk({tag, "_ovf"}, 32'(rsp_overflow), 32'(ovf));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        ovf_clr   = 1'b0;

        // Reset held for 3 cycles, then released with no requests.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle_outputs("rst");
            chk("rst_id", 32'(rsp_id), 32'h0);
            chk("rst_sum", 32'(rsp_sum), 32'h0);
            chk("rst_ovf", 32'(rsp_overflow), 32'h0);
            chk("rst_sticky", 32'(ovf_sticky), 32'h0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle_outputs("idle");
            chk("idle_sticky", 32'(ovf_sticky), 32'h0);
        end

        // req0: 7FFF + 0001 -> 0x08000, signed overflow.
        req_a[0 +: N] = 16'h7FFF;
        req_b[0 +: N] = 16'h0001;
        req_valid = 2'b01;
        #1;
        chk("add0_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        chk("add0_busy", 32'(busy), 32'h1);
        chk("add0_compute_valid", 32'(rsp_valid), 32'h0);
        chk("add0_compute_ready", 32'(req_ready), 32'h0);
        tick();
        chk_rsp("add0", 1'b0, 17'h08000, 1'b1);
        chk("add0_sticky", 32'(ovf_sticky), 32'h1);
        rsp_ready = 1'b1;
        tick();
        chk_idle_outputs("add0_done");
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("add0_clr", 32'(ovf_sticky), 32'h0);

        // req1: FFFF + 0001 -> carry out only.
        req_a[N +: N] = 16'hFFFF;
        req_b[N +: N] = 16'h0001;
        req_valid = 2'b10;
        #1;
        chk("add1_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        tick();
        chk_rsp("add1", 1'b1, 17'h10000, 1'b0);
        chk("add1_sticky", 32'(ovf_sticky), 32'h0);
        tick();
        chk_idle_outputs("add1_done");

        // Round robin, both valid, consumer always ready: 0,1,0,1 every 3 cycles.
        req_a[0 +: N] = 16'h0001; req_b[0 +: N] = 16'h0002;
        req_a[N +: N] = 16'h0003; req_b[N +: N] = 16'h0004;
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            chk("rr_compute_ready", 32'(req_ready), 32'h0);
            tick();
            chk("rr_resp_ready", 32'(req_ready), 32'h0);
            chk_rsp("rr", (k % 2 == 0) ? 1'b0 : 1'b1,
                    (k % 2 == 0) ? 17'h00003 : 17'h00007, 1'b0);
            tick();
        end

        // Backpressure: grant 0 (pointer back at 0), consumer stalls 5 cycles.
        rsp_ready = 1'b0;
        req_a[0 +: N] = 16'h1234; req_b[0 +: N] = 16'h1111;
        chk("bp_grant", 32'(req_ready), 32'h1);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk_rsp("bp_hold", 1'b0, 17'h02345, 1'b0);
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_busy", 32'(busy), 32'h1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_done_valid", 32'(rsp_valid), 32'h0);
        chk("bp_done_busy", 32'(busy), 32'h0);
        chk("bp_next_grant", 32'(req_ready), 32'h2);
        req_valid = 2'b00;

        // Overflow capture coincides with ovf_clr: set wins; clear alone next cycle.
        rsp_ready = 1'b0;
        req_a[N +: N] = 16'h8000; req_b[N +: N] = 16'h8000;
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        ovf_clr = 1'b1;
        tick();
        chk_rsp("ovfclr", 1'b1, 17'h10000, 1'b1);
        chk("ovfclr_set_wins", 32'(ovf_sticky), 32'h1);
        tick();
        chk("ovfclr_clear", 32'(ovf_sticky), 32'h0);
        ovf_clr = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk_idle_outputs("ovfclr_done");

        // Reset during COMPUTE aborts without a response.
        req_a[0 +: N] = 16'h0001; req_b[0 +: N] = 16'h0001;
        req_valid = 2'b01;
        tick();
        chk("abort_busy_before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("abort_in_rst");
        req_valid = 2'b00;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle_outputs("abort_after");
            chk("abort_sum", 32'(rsp_sum), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
